// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO.
// Sends 8 data bits LSB-first, an optional parity bit and one stop bit, at a fixed baud divider.
// Queued bytes go out back-to-back with no idle gap between frames.
module uart_tx_fifo #(
   parameter int unsigned BAUD_DIV   = 868,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [7:0]                    tx_data_i,
   input  logic                          tx_valid_i,
   output logic                          tx_ready_o,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned BaudW = $clog2(BAUD_DIV);
   localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
   localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   state_e           state_q, state_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d, byte_q, byte_d;
   logic             tx_q, tx_d;
   logic             push, pop, load, fifo_empty, baud_end;

   assign tx_ready_o = (cnt_q != CntFull);
   assign fifo_empty = (cnt_q == '0);
   assign push       = tx_valid_i && tx_ready_o;
   assign baud_end   = (baud_q == BaudLast);

   // FIFO pointer and occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // FIFO storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= tx_data_i;
   end

   // Frame FSM next-state; load pops the head byte and starts a new frame
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      tx_d    = tx_q;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            baud_d = '0;
            tx_d   = 1'b1;
            load   = !fifo_empty;
         end
         StStart: begin
            baud_d = baud_q + 1'b1;
            if (baud_end) begin
               baud_d  = '0;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            baud_d = baud_q + 1'b1;
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  if (PARITY_EN) begin
                     tx_d    = ^byte_q ^ PARITY_ODD;
                     state_d = StParity;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = StStop;
                  end
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
               end
            end
         end
         StParity: begin
            baud_d = baud_q + 1'b1;
            if (baud_end) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               state_d = StStop;
            end
         end
         StStop: begin
            baud_d = baud_q + 1'b1;
            if (baud_end) begin
               baud_d  = '0;
               state_d = StIdle;
               load    = !fifo_empty;
            end
         end
         default: state_d = StIdle;
      endcase
      if (load) begin
         shift_d = mem_q[rd_ptr_q];
         byte_d  = mem_q[rd_ptr_q];
         tx_d    = 1'b0;
         baud_d  = '0;
         state_d = StStart;
      end
      pop = load;
   end

   // State registers, asynchronously cleared to an idle line
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         byte_q   <= '0;
         tx_q     <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         byte_q   <= byte_d;
         tx_q     <= tx_d;
      end
   end

   assign tx_o       = tx_q;
   assign busy_o     = (state_q != StIdle) || !fifo_empty;
   assign fifo_cnt_o = cnt_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level model checked every cycle plus hand-computed line samples.
module tb_uart_tx_fifo;
   localparam int B = 4;
   localparam int D = 4;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;

   logic       tx_ready_o, tx_o, busy_o;
   logic [2:0] fifo_cnt_o;
   logic       ready_pe, tx_pe, busy_pe;
   logic [2:0] cnt_pe;
   logic       ready_po, tx_po, busy_po;
   logic [2:0] cnt_po;

   uart_tx_fifo #(.BAUD_DIV(B), .FIFO_DEPTH(D), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
      .tx_ready_o(tx_ready_o), .tx_o(tx_o), .busy_o(busy_o), .fifo_cnt_o(fifo_cnt_o));
   uart_tx_fifo #(.BAUD_DIV(B), .FIFO_DEPTH(D), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
      .clk_i(clk_i), .rst_i(rst_i), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
      .tx_ready_o(ready_pe), .tx_o(tx_pe), .busy_o(busy_pe), .fifo_cnt_o(cnt_pe));
   uart_tx_fifo #(.BAUD_DIV(B), .FIFO_DEPTH(D), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_po (
      .clk_i(clk_i), .rst_i(rst_i), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
      .tx_ready_o(ready_po), .tx_o(tx_po), .busy_o(busy_po), .fifo_cnt_o(cnt_po));

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit cmp_en = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: a byte queue plus the position inside the frame on the line
   logic [7:0] mq[$];
   logic [7:0] cur = 8'h00;
   bit         in_frame = 1'b0;
   int         t = 0;

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      return 1'b1;
   endfunction

   initial begin
      forever begin
         bit do_push;
         @(posedge clk_i or posedge rst_i);
         if (rst_i) begin
            mq.delete();
            in_frame = 1'b0;
            t = 0;
         end else begin
            do_push = tx_valid && (mq.size() != D);
            if (in_frame) begin
               t++;
               if (t == 10 * B) in_frame = 1'b0;
            end
            if (!in_frame && mq.size() > 0) begin
               cur = mq.pop_front();
               in_frame = 1'b1;
               t = 0;
            end
            if (do_push) mq.push_back(tx_data);
         end
      end
   end

   // Per-cycle comparison of the no-parity instance against the model
   initial begin
      forever begin
         logic exp_tx;
         @(negedge clk_i);
         if (cmp_en) begin
            exp_tx = in_frame ? frame_bit(cur, t / B) : 1'b1;
            check("m_tx", 32'(tx_o), 32'(exp_tx));
            check("m_cnt", 32'(fifo_cnt_o), 32'(mq.size()));
            check("m_ready", 32'(tx_ready_o), 32'(mq.size() != D));
            check("m_busy", 32'(busy_o), 32'(in_frame || mq.size() != 0));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Sample at the falling edge following rising edge n
   task automatic wait_cyc(input int n);
      do @(negedge clk_i); while (cyc < n);
   endtask

   task automatic push(input logic [7:0] b, output int edge_no);
      bit was;
      int guard;
      guard = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      do begin
         was = tx_ready_o;
         @(posedge clk_i);
         #1;
         guard++;
      end while (!was && guard < 2000);
      if (!was) check("push_timeout", 32'd0, 32'd1);
      edge_no = cyc;
   endtask

   task automatic do_reset();
      @(posedge clk_i);
      #2 rst_i = 1'b1;
      tx_valid = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #3 rst_i = 1'b0;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int k, k1, k5;
      logic [9:0] pat;

      // Reset state, then asynchronous reset in the middle of a cycle
      repeat (2) @(posedge clk_i);
      #3 rst_i = 1'b0;
      cmp_en = 1'b1;
      @(posedge clk_i);
      #1;
      check("rst_tx", 32'(tx_o), 32'd1);
      check("rst_ready", 32'(tx_ready_o), 32'd1);
      push(8'h3C, k);
      tx_valid = 1'b0;
      wait_cyc(k + 6);
      check("pre_rst_busy", 32'(busy_o), 32'd1);
      @(posedge clk_i);
      #3 rst_i = 1'b1;
      #1;
      check("arst_tx", 32'(tx_o), 32'd1);
      check("arst_ready", 32'(tx_ready_o), 32'd1);
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_cnt", 32'(fifo_cnt_o), 32'd0);
      @(posedge clk_i);
      #3 rst_i = 1'b0;

      // Single frame of 0xA5: start, data LSB-first, stop
      do_reset();
      push(8'hA5, k);
      tx_valid = 1'b0;
      check("a5_idle_at_k", 32'(tx_o), 32'd1);
      pat = 10'b1_10100101_0;
      for (int i = 0; i < 10; i++) begin
         wait_cyc(k + 2 + 4 * i);
         check($sformatf("a5_bit%0d", i), 32'(tx_o), 32'(pat[i]));
      end
      wait_cyc(k + 40);
      check("a5_busy_last", 32'(busy_o), 32'd1);
      wait_cyc(k + 41);
      check("a5_busy_done", 32'(busy_o), 32'd0);

      // Six bytes back-to-back into a four-entry FIFO
      do_reset();
      push(8'h11, k);
      push(8'h22, k1);
      push(8'h33, k1);
      push(8'h44, k1);
      push(8'h55, k1);
      check("full_cnt", 32'(fifo_cnt_o), 32'd4);
      check("full_ready", 32'(tx_ready_o), 32'd0);
      push(8'h66, k5);
      tx_valid = 1'b0;
      check("sixth_accept_edge", 32'(k5 - k), 32'd42);
      wait_cyc(k + 240);
      check("six_busy_last", 32'(busy_o), 32'd1);
      wait_cyc(k + 241);
      check("six_busy_done", 32'(busy_o), 32'd0);

      // 0x00 then 0xFF: stop of first abuts start of second
      do_reset();
      push(8'h00, k);
      push(8'hFF, k1);
      tx_valid = 1'b0;
      wait_cyc(k + 40);
      check("b2b_stop", 32'(tx_o), 32'd1);
      wait_cyc(k + 41);
      check("b2b_start", 32'(tx_o), 32'd0);
      wait_cyc(k + 45);
      check("b2b_ff_bit0", 32'(tx_o), 32'd1);
      wait_cyc(k + 80);
      check("b2b_busy_last", 32'(busy_o), 32'd1);
      wait_cyc(k + 81);
      check("b2b_busy_done", 32'(busy_o), 32'd0);

      // Parity on 0x07 (three ones): even -> 1, odd -> 0, frame 44 cycles
      do_reset();
      push(8'h07, k);
      tx_valid = 1'b0;
      wait_cyc(k + 34);
      check("par_bit7", 32'(tx_pe), 32'd0);
      wait_cyc(k + 38);
      check("par_even", 32'(tx_pe), 32'd1);
      check("par_odd", 32'(tx_po), 32'd0);
      wait_cyc(k + 42);
      check("par_stop_e", 32'(tx_pe), 32'd1);
      check("par_stop_o", 32'(tx_po), 32'd1);
      wait_cyc(k + 44);
      check("par_busy_last", 32'(busy_pe), 32'd1);
      wait_cyc(k + 45);
      check("par_busy_done_e", 32'(busy_pe), 32'd0);
      check("par_busy_done_o", 32'(busy_po), 32'd0);

      // Reset during data bit 3 of 0x55 with 0x33 queued
      do_reset();
      push(8'h55, k);
      push(8'h33, k1);
      tx_valid = 1'b0;
      wait_cyc(k + 18);
      check("mid_bit3", 32'(tx_o), 32'd0);
      #2 rst_i = 1'b1;
      #1;
      check("mid_rst_tx", 32'(tx_o), 32'd1);
      check("mid_rst_cnt", 32'(fifo_cnt_o), 32'd0);
      check("mid_rst_busy", 32'(busy_o), 32'd0);
      @(posedge clk_i);
      #3 rst_i = 1'b0;
      repeat (100) @(posedge clk_i);
      #1;
      check("post_rst_tx", 32'(tx_o), 32'd1);
      check("post_rst_busy", 32'(busy_o), 32'd0);
      check("post_rst_tx_pe", 32'(tx_pe), 32'd1);

      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
